microsequencer: RTL and testbench
=================================

Name: microsequencer

Overview:
- Next-state engine for the microprogrammed ARM control unit. It drives the 8-bit address into the 256x64 control ROM and reads back the 64-bit control word.
- Registers that word as the datapath control register.
- Chooses the next microstate from the word's N2-N0, INV, MI, S2-S0 and CR7-CR0 fields, plus datapath status.
- Supports sequential increment, instruction-decode dispatch, jumps, conditional branches, memory-wait holds, and a small call/return stack.

Parameters:
- ADDR_W, 8, microstate/ROM address width
- CW_W, 64, control word width
- RESET_STATE, 8'd0, state forced by reset
- FETCH_STATE, 8'd1, target of FETCH and of stack underflow
- STACK_DEPTH, 4, return-address stack entries

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- rom_data  in  64  control word for the current rom_addr (combinational ROM)
- encoder_state  in  8  dispatch address from the instruction encoder
- cond_in  in  1  ARM condition tester result
- moc  in  1  memory operation complete
- lsm_done  in  1  load/store-multiple finished
- zero  in  1  ALU zero flag
- rom_addr  out  8  current microstate (= state_q)
- ctrl_word  out  64  registered control word to the datapath
- stall  out  1  MI interlock active this cycle
- stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high; it is sampled on clk rising edge and overrides all other activity, including an in-flight stall or wait.
- Reset values:
  - state_q = RESET_STATE
  - ctrl_word = 0
  - stack empty (sp = 0)
  - stack_err = 0
  - stall = 0
- Field decode from rom_data:
  - N = [57:55], INV = [54], MI = [53], S = [52:50], TGT = [41:34] (CR7-CR0).
  - CR15-CR8 is ignored by the sequencer and only passed through.
- Condition select c_raw by S:
  - 000 cond_in, 001 moc, 010 lsm_done, 011 zero, 1xx constant 1.
  - c = c_raw ^ INV.
- inc = state_q + 1, mod 256; 8'hFF wraps to 8'h00.
- Next-state by N:
  - 000 ENC: encoder_state
  - 001 FETCH: FETCH_STATE
  - 010 JUMP: TGT
  - 011 COND: c ? TGT : inc
  - 100 INC: inc
  - 101 WAIT: c ? inc : state_q
  - 110 CALL: push inc, then TGT
  - 111 RET: pop → top entry
- Interlock:
  - If MI=1 and moc=0, stall=1 (combinational).
  - While stalled: state_q, stack and sp hold; ctrl_word still loads rom_data, so the current word is re-applied.
  - MI has priority over every N code.
- Every non-reset edge: ctrl_word <= rom_data. Latency from rom_addr change to ctrl_word is exactly 1 cycle.
- Stack is LIFO, depth STACK_DEPTH.
  - CALL with full stack: the oldest entry is discarded, the new entry is pushed, and stack_err is set.
  - RET with empty stack: next = FETCH_STATE, sp stays 0, stack_err is set.
  - stack_err clears only on reset.
- N is decoded from rom_data (current state's word), not from ctrl_word. Status inputs are sampled in the same cycle as that decode.

Decomposition:
- Shared package microseq_pkg holds:
  - field bit-position constants (N_HI/N_LO, INV_BIT, MI_BIT, S_HI/S_LO, TGT_HI/TGT_LO)
  - N codes (N_ENC ... N_RET)
  - S codes
  - RESET_STATE/FETCH_STATE defaults
- One natural sub-module, microseq_stack: a parameterised LIFO with push/pop/full/empty/overflow/underflow outputs.
- Next-state mux and condition select stay inline.

Test Plan:
- Reset mid-WAIT at state 8'd10, then release → rom_addr=0 and ctrl_word=0 in the reset cycle; 1 cycle after release ctrl_word=rom_data(0).
- State 8'd5 with N=100 → rom_addr=6 next cycle. State 8'hFF with N=100 → rom_addr=8'h00.
- N=011, S=000, TGT=8'd40 at state 8'd20:
  - cond_in=1 → 40
  - cond_in=0 → 21
  - with INV=1: cond_in=1 → 21
- N=101, S=001 at 8'd30, moc low for 3 cycles then high → rom_addr stays 30 for 3 cycles, then 31. Repeat with MI=1, N=100 → stall=1 for those 3 cycles, with the same hold.
- N=000, encoder_state=8'd25 → rom_addr=25.
- CALL chain: CALL TGT=50 at 8'd2, CALL TGT=60 at 50, RET at 60 → 51; RET at 51 → 3.
- Five nested CALLs → stack_err=1 and the first return address is lost. RET from empty → rom_addr=1, stack_err=1.

Source files
------------

// File: rtl/microseq_pkg.sv
// Shared field positions, next-state/condition codes and default states for the
// microsequencer that walks the 256x64 ARM control ROM.
package microseq_pkg;

    localparam int N_HI    = 57;
    localparam int N_LO    = 55;
    localparam int INV_BIT = 54;
    localparam int MI_BIT  = 53;
    localparam int S_HI    = 52;
    localparam int S_LO    = 50;
    localparam int TGT_HI  = 41;
    localparam int TGT_LO  = 34;

    typedef enum logic [2:0] {
        N_ENC   = 3'b000,
        N_FETCH = 3'b001,
        N_JUMP  = 3'b010,
        N_COND  = 3'b011,
        N_INC   = 3'b100,
        N_WAIT  = 3'b101,
        N_CALL  = 3'b110,
        N_RET   = 3'b111
    } n_code_t;

    // Any S code with bit 2 set selects a constant-true condition.
    localparam logic [2:0] S_COND = 3'b000;
    localparam logic [2:0] S_MOC  = 3'b001;
    localparam logic [2:0] S_LSM  = 3'b010;
    localparam logic [2:0] S_ZERO = 3'b011;

    localparam logic [7:0] RESET_STATE_DEF = 8'd0;
    localparam logic [7:0] FETCH_STATE_DEF = 8'd1;

endpackage

// File: rtl/microseq_stack.sv
// Return-address LIFO; entry 0 is always the top, so a push into a full stack
// simply shifts the oldest entry out of the far end.
module microseq_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty,
    output logic         overflow,
    output logic         underflow
);

    localparam int SP_W = $clog2(DEPTH + 1);

    logic [W-1:0]    mem [DEPTH];
    logic [SP_W-1:0] sp;

    assign full      = (sp == SP_W'(DEPTH));
    assign empty     = (sp == '0);
    assign overflow  = push && full;
    assign underflow = pop && empty;
    assign top       = mem[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[0] <= push_data;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end else if (pop && !empty) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem[i] <= mem[i+1];
            end
        end
    end

endmodule

// File: rtl/microsequencer.sv
// Next-state engine for the microprogrammed control unit: decodes the current
// ROM word, picks the next microstate and registers the word for the datapath.
module microsequencer
    import microseq_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                CW_W        = 64,
    parameter logic [ADDR_W-1:0] RESET_STATE = RESET_STATE_DEF,
    parameter logic [ADDR_W-1:0] FETCH_STATE = FETCH_STATE_DEF,
    parameter int                STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CW_W-1:0]   rom_data,
    input  logic [ADDR_W-1:0] encoder_state,
    input  logic              cond_in,
    input  logic              moc,
    input  logic              lsm_done,
    input  logic              zero,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [CW_W-1:0]   ctrl_word,
    output logic              stall,
    output logic              stack_err
);

    logic [ADDR_W-1:0] state_q;
    logic [ADDR_W-1:0] state_d;
    logic [ADDR_W-1:0] inc;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] stk_top;
    n_code_t           n_code;
    logic [2:0]        s_code;
    logic              c_raw;
    logic              c;
    logic              push;
    logic              pop;
    logic              stk_full;
    logic              stk_empty;
    logic              stk_over;
    logic              stk_under;

    assign rom_addr = state_q;
    assign stall    = !reset && rom_data[MI_BIT] && !moc;

    always_comb begin
        n_code  = n_code_t'(rom_data[N_HI:N_LO]);
        s_code  = rom_data[S_HI:S_LO];
        tgt     = rom_data[TGT_HI:TGT_LO];
        inc     = state_q + ADDR_W'(1);
        push    = 1'b0;
        pop     = 1'b0;
        state_d = inc;

        case (s_code)
            S_COND:  c_raw = cond_in;
            S_MOC:   c_raw = moc;
            S_LSM:   c_raw = lsm_done;
            S_ZERO:  c_raw = zero;
            default: c_raw = 1'b1;
        endcase
        c = c_raw ^ rom_data[INV_BIT];

        case (n_code)
            N_ENC:   state_d = encoder_state;
            N_FETCH: state_d = FETCH_STATE;
            N_JUMP:  state_d = tgt;
            N_COND:  state_d = c ? tgt : inc;
            N_INC:   state_d = inc;
            N_WAIT:  state_d = c ? inc : state_q;
            N_CALL: begin
                push    = !stall;
                state_d = tgt;
            end
            N_RET: begin
                pop     = !stall;
                state_d = stk_empty ? FETCH_STATE : stk_top;
            end
            default: state_d = inc;
        endcase

        // The memory interlock freezes sequencing regardless of the N code.
        if (stall) begin
            state_d = state_q;
        end
    end

    microseq_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty),
        .overflow  (stk_over),
        .underflow (stk_under)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RESET_STATE;
            ctrl_word <= '0;
            stack_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_word <= rom_data;
            stack_err <= stack_err || stk_over || stk_under;
        end
    end

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench: a behavioural ROM array feeds the sequencer and each step
// compares rom_addr / ctrl_word / stall / stack_err against hand-derived values.
module tb_microsequencer;

    logic        clk;
    logic        reset;
    logic [63:0] rom_data;
    logic [7:0]  encoder_state;
    logic        cond_in;
    logic        moc;
    logic        lsm_done;
    logic        zero;
    logic [7:0]  rom_addr;
    logic [63:0] ctrl_word;
    logic        stall;
    logic        stack_err;

    logic [63:0] rom [256];
    int          n_pass;
    int          n_total;

    assign rom_data = rom[rom_addr];

    microsequencer dut (
        .clk           (clk),
        .reset         (reset),
        .rom_data      (rom_data),
        .encoder_state (encoder_state),
        .cond_in       (cond_in),
        .moc           (moc),
        .lsm_done      (lsm_done),
        .zero          (zero),
        .rom_addr      (rom_addr),
        .ctrl_word     (ctrl_word),
        .stall         (stall),
        .stack_err     (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input logic [2:0] n, input logic inv, input logic mi,
                                       input logic [2:0] s, input logic [7:0] tgt);
        logic [63:0] w;
        w = 64'h0;
        w[63:58] = 6'h2A;
        w[57:55] = n;
        w[54]    = inv;
        w[53]    = mi;
        w[52:50] = s;
        w[49:42] = 8'hA5;
        w[41:34] = tgt;
        w[33:0]  = 34'h2_DEAD_BEEF;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = mk(3'b100, 1'b0, 1'b0, 3'b000, 8'd0);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        encoder_state = 8'd0;
        cond_in = 1'b0;
        moc = 1'b0;
        lsm_done = 1'b0;
        zero = 1'b0;
        clear_rom();

        // Reset in the middle of a stalled WAIT at state 10
        rom[0]  = mk(3'b010, 1'b0, 1'b0, 3'b000, 8'd10);
        rom[10] = mk(3'b101, 1'b0, 1'b1, 3'b001, 8'd0);
        do_reset();
        tick();
        chk("release_ctrl", ctrl_word, rom[0]);
        chk("jump10", {56'd0, rom_addr}, 64'd10);
        tick();
        chk("wait_hold", {56'd0, rom_addr}, 64'd10);
        chk("wait_stall", {63'd0, stall}, 64'd1);
        reset = 1'b1;
        tick();
        chk("rst_addr", {56'd0, rom_addr}, 64'd0);
        chk("rst_ctrl", ctrl_word, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        chk("rst_err", {63'd0, stack_err}, 64'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_ctrl", ctrl_word, rom[0]);
        chk("post_rst_addr", {56'd0, rom_addr}, 64'd10);

        // Sequential increment and wrap
        clear_rom();
        rom[0] = mk(3'b010, 1'b0, 1'b0, 3'b000, 8'd5);
        do_reset();
        tick();
        tick();
        chk("inc5", {56'd0, rom_addr}, 64'd6);
        rom[0] = mk(3'b010, 1'b0, 1'b0, 3'b000, 8'hFF);
        do_reset();
        tick();
        chk("at_ff", {56'd0, rom_addr}, 64'hFF);
        tick();
        chk("wrap", {56'd0, rom_addr}, 64'h00);

        // Conditional branch at 20 to 40
        rom[0]  = mk(3'b010, 1'b0, 1'b0, 3'b000, 8'd20);
        rom[20] = mk(3'b011, 1'b0, 1'b0, 3'b000, 8'd40);
        cond_in = 1'b1;
        do_reset(); tick(); tick();
        chk("cond_taken", {56'd0, rom_addr}, 64'd40);
        cond_in = 1'b0;
        do_reset(); tick(); tick();
        chk("cond_not", {56'd0, rom_addr}, 64'd21);
        rom[20] = mk(3'b011, 1'b1, 1'b0, 3'b000, 8'd40);
        cond_in = 1'b1;
        do_reset(); tick(); tick();
        chk("cond_inv1", {56'd0, rom_addr}, 64'd21);
        cond_in = 1'b0;
        do_reset(); tick(); tick();
        chk("cond_inv0", {56'd0, rom_addr}, 64'd40);
        rom[20] = mk(3'b011, 1'b0, 1'b0, 3'b011, 8'd40);
        zero = 1'b1;
        do_reset(); tick(); tick();
        chk("cond_zero", {56'd0, rom_addr}, 64'd40);
        zero = 1'b0;

        // WAIT on moc at 30
        rom[0]  = mk(3'b010, 1'b0, 1'b0, 3'b000, 8'd30);
        rom[30] = mk(3'b101, 1'b0, 1'b0, 3'b001, 8'd0);
        moc = 1'b0;
        do_reset(); tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_moc", {56'd0, rom_addr}, 64'd30);
        end
        moc = 1'b1;
        tick();
        chk("wait_done", {56'd0, rom_addr}, 64'd31);

        // MI interlock over INC at 30
        rom[30] = mk(3'b100, 1'b0, 1'b1, 3'b000, 8'd0);
        moc = 1'b0;
        do_reset(); tick();
        chk("mi_stall0", {63'd0, stall}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mi_hold", {56'd0, rom_addr}, 64'd30);
            chk("mi_stall", {63'd0, stall}, 64'd1);
            chk("mi_ctrl", ctrl_word, rom[30]);
        end
        moc = 1'b1;
        #1;
        chk("mi_release", {63'd0, stall}, 64'd0);
        tick();
        chk("mi_adv", {56'd0, rom_addr}, 64'd31);
        moc = 1'b0;

        // Encoder dispatch
        rom[0] = mk(3'b000, 1'b0, 1'b0, 3'b000, 8'd0);
        encoder_state = 8'd25;
        do_reset(); tick();
        chk("enc", {56'd0, rom_addr}, 64'd25);
        encoder_state = 8'd0;

        // CALL/RET chain
        clear_rom();
        rom[0]  = mk(3'b010, 1'b0, 1'b0, 3'b000, 8'd2);
        rom[2]  = mk(3'b110, 1'b0, 1'b0, 3'b000, 8'd50);
        rom[50] = mk(3'b110, 1'b0, 1'b0, 3'b000, 8'd60);
        rom[60] = mk(3'b111, 1'b0, 1'b0, 3'b000, 8'd0);
        rom[51] = mk(3'b111, 1'b0, 1'b0, 3'b000, 8'd0);
        do_reset(); tick(); tick(); tick();
        chk("call60", {56'd0, rom_addr}, 64'd60);
        tick();
        chk("ret51", {56'd0, rom_addr}, 64'd51);
        tick();
        chk("ret3", {56'd0, rom_addr}, 64'd3);
        chk("chain_err", {63'd0, stack_err}, 64'd0);

        // Five nested CALLs overflow the 4-entry stack
        clear_rom();
        rom[0]   = mk(3'b010, 1'b0, 1'b0, 3'b000, 8'd100);
        rom[100] = mk(3'b110, 1'b0, 1'b0, 3'b000, 8'd110);
        rom[110] = mk(3'b110, 1'b0, 1'b0, 3'b000, 8'd120);
        rom[120] = mk(3'b110, 1'b0, 1'b0, 3'b000, 8'd130);
        rom[130] = mk(3'b110, 1'b0, 1'b0, 3'b000, 8'd140);
        rom[140] = mk(3'b110, 1'b0, 1'b0, 3'b000, 8'd150);
        rom[150] = mk(3'b111, 1'b0, 1'b0, 3'b000, 8'd0);
        rom[141] = mk(3'b111, 1'b0, 1'b0, 3'b000, 8'd0);
        rom[131] = mk(3'b111, 1'b0, 1'b0, 3'b000, 8'd0);
        rom[121] = mk(3'b111, 1'b0, 1'b0, 3'b000, 8'd0);
        rom[111] = mk(3'b111, 1'b0, 1'b0, 3'b000, 8'd0);
        do_reset(); tick();
        tick(); tick(); tick(); tick();
        chk("call4_addr", {56'd0, rom_addr}, 64'd140);
        chk("call4_err", {63'd0, stack_err}, 64'd0);
        tick();
        chk("call5_addr", {56'd0, rom_addr}, 64'd150);
        chk("ovf_err", {63'd0, stack_err}, 64'd1);
        tick(); chk("ovf_ret1", {56'd0, rom_addr}, 64'd141);
        tick(); chk("ovf_ret2", {56'd0, rom_addr}, 64'd131);
        tick(); chk("ovf_ret3", {56'd0, rom_addr}, 64'd121);
        tick(); chk("ovf_ret4", {56'd0, rom_addr}, 64'd111);
        tick(); chk("ovf_lost", {56'd0, rom_addr}, 64'd1);
        chk("ovf_sticky", {63'd0, stack_err}, 64'd1);

        // RET from an empty stack right after reset
        clear_rom();
        rom[0] = mk(3'b111, 1'b0, 1'b0, 3'b000, 8'd0);
        do_reset();
        chk("err_cleared", {63'd0, stack_err}, 64'd0);
        tick();
        chk("unf_addr", {56'd0, rom_addr}, 64'd1);
        chk("unf_err", {63'd0, stack_err}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
